rv32_data_mem: RTL and testbench

RV32_DATA_MEM -- requirements
Module: rv32_data_mem

---
 rtl/rv32_data_mem_if.sv | 25 ++
 rtl/rv32_data_mem.sv | 101 ++++++++++
 tb/tb_rv32_data_mem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv32_data_mem_if.sv
// Data-memory request/response bundle between the load/store unit (master)
// and rv32_data_mem (slave).
interface rv32_data_mem_if;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_wait_out;
  logic        data_fault_out;

  modport slave (
    input  data_read_in, data_write_in, data_write_mask_in,
           data_address_in, data_write_value_in,
    output data_read_value_out, data_ready_out, data_wait_out, data_fault_out
  );

  modport master (
    output data_read_in, data_write_in, data_write_mask_in,
           data_address_in, data_write_value_in,
    input  data_read_value_out, data_ready_out, data_wait_out, data_fault_out
  );
endinterface

// File: rtl/rv32_data_mem.sv
// RV32 data RAM with fixed request latency and byte-lane writes.
// Optional macro RV32_DATA_MEM_FAULT_EN flags out-of-range addresses.
module rv32_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  rv32_data_mem_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_accept;
  logic            w_oob;
  logic [AW-1:0]   w_idx;

  assign w_req    = bus.data_read_in | bus.data_write_in;
  assign w_accept = (r_state == IDLE) & w_req;
  assign w_idx    = bus.data_address_in[AW+1:2];

`ifdef RV32_DATA_MEM_FAULT_EN
  logic r_fault;

  assign w_oob = |bus.data_address_in[31:AW+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_oob;
  end

  assign bus.data_fault_out = (r_state == DONE) & r_fault;
`else
  assign w_oob              = 1'b0;
  assign bus.data_fault_out = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_state_next = DONE;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) w_state_next = DONE;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        // A combined read/write performs only the write and returns zero.
        r_rdata <= (bus.data_write_in | w_oob) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would cost a full write sweep.
  always_ff @(posedge clk) begin
    if (w_accept && bus.data_write_in && !w_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_write_mask_in[i])
          r_mem[w_idx][8*i +: 8] <= bus.data_write_value_in[8*i +: 8];
      end
    end
  end

  assign bus.data_ready_out      = (r_state == DONE);
  assign bus.data_wait_out       = w_req & (r_state != DONE);
  assign bus.data_read_value_out = bus.data_ready_out ? r_rdata : 32'd0;
endmodule

// File: tb/tb_rv32_data_mem.sv
// Directed bench for rv32_data_mem: one LATENCY=1 and one LATENCY=4 instance.
module tb_rv32_data_mem;
  logic clk = 1'b0;
  logic rst1, rst4;
  int   total = 0;
  int   bad   = 0;
  int   sel   = 1;

`ifdef RV32_DATA_MEM_FAULT_EN
  localparam logic        EXP_FAULT = 1'b1;
  localparam logic [31:0] EXP_W0    = 32'h0000_0000;
`else
  localparam logic        EXP_FAULT = 1'b0;
  localparam logic [31:0] EXP_W0    = 32'h1234_5678;
`endif

  always #5 clk = ~clk;

  rv32_data_mem_if if1 ();
  rv32_data_mem_if if4 ();

  rv32_data_mem #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  rv32_data_mem #(.DEPTH_WORDS(1024), .LATENCY(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4.slave));

  logic        ready_s, wait_s, fault_s;
  logic [31:0] rdata_s;
  assign ready_s = (sel == 4) ? if4.data_ready_out      : if1.data_ready_out;
  assign wait_s  = (sel == 4) ? if4.data_wait_out       : if1.data_wait_out;
  assign fault_s = (sel == 4) ? if4.data_fault_out      : if1.data_fault_out;
  assign rdata_s = (sel == 4) ? if4.data_read_value_out : if1.data_read_value_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [3:0] mask,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 4) begin
      if4.data_read_in = rd; if4.data_write_in = wr; if4.data_write_mask_in = mask;
      if4.data_address_in = addr; if4.data_write_value_in = wdata;
    end else begin
      if1.data_read_in = rd; if1.data_write_in = wr; if1.data_write_mask_in = mask;
      if1.data_address_in = addr; if1.data_write_value_in = wdata;
    end
  endtask

  // One full request on the selected instance: wait for lat cycles, then ready.
  task automatic req(input string tag, input int lat, input logic rd, input logic wr,
                     input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_fault);
    @(posedge clk); #1;
    drive(rd, wr, mask, addr, wdata);
    for (int c = 0; c < lat; c++) begin
      #1;
      check({tag, ".wait"}, 32'(wait_s), 32'd1);
      check({tag, ".early_ready"}, 32'(ready_s), 32'd0);
      check({tag, ".early_data"}, rdata_s, 32'd0);
      @(posedge clk); #1;
    end
    #1;
    check({tag, ".ready"}, 32'(ready_s), 32'd1);
    check({tag, ".wait_done"}, 32'(wait_s), 32'd0);
    check({tag, ".data"}, rdata_s, exp_rdata);
    check({tag, ".fault"}, 32'(fault_s), 32'(exp_fault));
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    sel = 4; drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sel = 1; drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    check("rst.ready", 32'(if1.data_ready_out), 32'd0);
    check("rst.data", if1.data_read_value_out, 32'd0);
    check("rst.fault", 32'(if1.data_fault_out), 32'd0);
    check("rst.wait_noreq", 32'(if1.data_wait_out), 32'd0);
    if1.data_read_in = 1'b1; #1;
    check("rst.wait_req", 32'(if1.data_wait_out), 32'd1);
    check("rst.ready_req", 32'(if1.data_ready_out), 32'd0);
    if1.data_read_in = 1'b0;
    @(posedge clk); #1; rst1 = 1'b0; rst4 = 1'b0;

    // LATENCY = 1 instance
    sel = 1;
    req("wr10", 1, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req("rd10", 1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req("wr10_lane2", 1, 1'b0, 1'b1, 4'b0100, 32'h10, 32'h00AA_0000, 32'h0, 1'b0);
    req("rd10_lane2", 1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_BEEF, 1'b0);
    req("wr10_nomask", 1, 1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    req("rd10_nomask", 1, 1'b1, 1'b0, 4'h0, 32'h13, 32'h0, 32'hDEAA_BEEF, 1'b0);
    req("wr30_full", 1, 1'b0, 1'b1, 4'hF, 32'h30, 32'hAAAA_AAAA, 32'h0, 1'b0);
    req("wr30_edges", 1, 1'b0, 1'b1, 4'b1001, 32'h30, 32'h1122_3344, 32'h0, 1'b0);
    req("rd30_edges", 1, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 32'h11AA_AA44, 1'b0);
    req("rdwr20", 1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h0000_0001, 32'h0, 1'b0);
    req("rd20", 1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0000_0001, 1'b0);
    req("wr0_clear", 1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0);
    req("wr1000", 1, 1'b0, 1'b1, 4'hF, 32'h1000, 32'h1234_5678, 32'h0, EXP_FAULT);
    req("rd0_alias", 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, EXP_W0, 1'b0);

    // LATENCY = 4 instance
    sel = 4;
    req("l4_wr10", 4, 1'b0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("l4_hold.ready%0d", c), 32'(ready_s), 32'((c == 4) || (c == 9)));
      check($sformatf("l4_hold.wait%0d", c), 32'(wait_s), 32'(!((c == 4) || (c == 9))));
      check($sformatf("l4_hold.data%0d", c), rdata_s,
            ((c == 4) || (c == 9)) ? 32'hCAFE_F00D : 32'h0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset in cycle 2 of a held read abandons it.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1; #1;
    check("l4_rst.ready", 32'(ready_s), 32'd0);
    check("l4_rst.data", rdata_s, 32'd0);
    check("l4_rst.fault", 32'(fault_s), 32'd0);
    check("l4_rst.wait_req", 32'(wait_s), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("l4_rst.wait_noreq", 32'(wait_s), 32'd0);
    @(posedge clk); #1; rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("l4_post.ready%0d", c), 32'(ready_s), 32'd0);
      check($sformatf("l4_post.data%0d", c), rdata_s, 32'd0);
      @(posedge clk); #1;
    end
    req("l4_rd10_after_rst", 4, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
